// File: rtl/dff_bank_arbiter_if.sv
// Requester <-> arbiter bus for the shared DFF register bank.
// Lock exists only when DFF_ARB_LOCK_EN is defined.
interface dff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       Req;
    logic [NREQ*WIDTH-1:0] WrData;
    logic [NREQ-1:0]       Grant;
    logic [NREQ-1:0]       Ack;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      Qbar;
    logic                  Busy;
`ifdef DFF_ARB_LOCK_EN
    logic [NREQ-1:0]       Lock;

    modport master (output Req, WrData, Lock, input Grant, Ack, Q, Qbar, Busy);
    modport slave  (input Req, WrData, Lock, output Grant, Ack, Q, Qbar, Busy);
`else
    modport master (output Req, WrData, input Grant, Ack, Q, Qbar, Busy);
    modport slave  (input Req, WrData, output Grant, Ack, Q, Qbar, Busy);
`endif
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter owning a WIDTH-bit Q/Qbar register bank.
// Define DFF_ARB_LOCK_EN to add the Lock port (back-to-back writes by one requester).
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Clear,
    dff_bank_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    sel, sel_n;
    logic [WIDTH-1:0] q, q_n, qbar;
    logic [NREQ-1:0]  grant, grant_n;
    logic [NREQ-1:0]  ack, ack_n;
    logic             busy;
    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    sel_inc;

    // First active request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.Req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign sel_inc = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        q_n     = q;
        grant_n = grant;
        ack_n   = '0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (found) begin
                    sel_n   = pick;
                    grant_n = NREQ'(1) << pick;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                grant_n = '0;
                if (bus.Req[sel]) begin
                    q_n     = bus.WrData[int'(sel)*WIDTH +: WIDTH];
                    ack_n   = NREQ'(1) << sel;
                    ptr_n   = sel_inc;
                    state_n = DONE;
                end else begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                grant_n = '0;
                state_n = IDLE;
`ifdef DFF_ARB_LOCK_EN
                // Locked requester keeps the bank; ptr already moved past it.
                if (bus.Req[sel] && bus.Lock[sel]) begin
                    grant_n = NREQ'(1) << sel;
                    state_n = GRANT;
                end
`endif
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            q     <= '0;
            qbar  <= '1;
            grant <= '0;
            ack   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            q     <= q_n;
            qbar  <= ~q_n;
            grant <= grant_n;
            ack   <= ack_n;
            busy  <= (state_n != IDLE);
        end
    end

    assign bus.Grant = grant;
    assign bus.Ack   = ack;
    assign bus.Q     = q;
    assign bus.Qbar  = qbar;
    assign bus.Busy  = busy;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: expected (Ack, Q) pushed with stimulus, popped on each Ack.
module tb_dff_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic Clock;
    logic Clear;
    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [NREQ-1:0]  ack;
        logic [WIDTH-1:0] q;
    } exp_t;

    exp_t sb[$];
    int   n_chk, n_pass;
    int   cyc, ack_cnt, last_ack_cyc, c0;
    bit   auto_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push_exp(input int i, input logic [WIDTH-1:0] d);
        exp_t e;
        e.ack = NREQ'(1) << i;
        e.q   = d;
        sb.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] d);
        bus.WrData[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock; sample #1 after the edge, score any Ack, emulate requesters dropping Req on Ack.
    task automatic tick();
        exp_t e;
        @(posedge Clock);
        #1;
        cyc++;
        if (bus.Ack != '0) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            chk("ack_grant_excl", {28'b0, bus.Grant}, 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {28'b0, bus.Ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack", {28'b0, bus.Ack}, {28'b0, e.ack});
                chk("q", {24'b0, bus.Q}, {24'b0, e.q});
                chk("qbar", {24'b0, bus.Qbar}, {24'b0, ~e.q});
            end
            if (auto_drop) bus.Req = bus.Req & ~bus.Ack;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        tick();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; ack_cnt = 0; last_ack_cyc = 0;
        auto_drop = 1'b1;
`ifdef DFF_ARB_LOCK_EN
        bus.Lock = '0;
`endif
        // Reset with random activity on the inputs
        Clear = 1'b0;
        bus.Req = NREQ'($urandom);
        bus.WrData = {$urandom, $urandom};
        tick(); tick();
        chk("rst_q", {24'b0, bus.Q}, 32'h00);
        chk("rst_qbar", {24'b0, bus.Qbar}, 32'hFF);
        chk("rst_grant", {28'b0, bus.Grant}, 32'h0);
        chk("rst_ack", {28'b0, bus.Ack}, 32'h0);
        chk("rst_busy", {31'b0, bus.Busy}, 32'h0);
        bus.Req = '0;
        Clear = 1'b1;
        tick();
        chk("rel_q", {24'b0, bus.Q}, 32'h00);
        chk("rel_qbar", {24'b0, bus.Qbar}, 32'hFF);
        chk("rel_grant", {28'b0, bus.Grant}, 32'h0);
        chk("rel_busy", {31'b0, bus.Busy}, 32'h0);

        // Single write from requester 2
        set_data(2, 8'hA5);
        push_exp(2, 8'hA5);
        bus.Req = 4'b0100;
        tick();
        chk("single_grant", {28'b0, bus.Grant}, 32'h4);
        chk("single_busy", {31'b0, bus.Busy}, 32'h1);
        chk("single_q_hold", {24'b0, bus.Q}, 32'h00);
        tick();
        chk("single_sb_empty", sb.size(), 0);
        tick();
        chk("single_busy_done", {31'b0, bus.Busy}, 32'h0);
        chk("single_ack_done", {28'b0, bus.Ack}, 32'h0);
        chk("single_q_keep", {24'b0, bus.Q}, 32'hA5);

        // Back to ptr=0, then full round-robin at one write per 3 cycles
        Clear = 1'b0; tick(); Clear = 1'b1;
        set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
        for (int i = 0; i < 4; i++) push_exp(i, 8'h11 * (i + 1));
        c0 = cyc;
        bus.Req = 4'b1111;
        drain("rr");
        chk("rr_throughput", last_ack_cyc - c0, 11);
        push_exp(0, 8'h11); push_exp(3, 8'h44);
        bus.Req = 4'b1001;
        drain("rr2");
        push_exp(0, 8'h11);
        bus.Req = 4'b0001;
        drain("rr3");

        // Wrap: grant 2 leaves ptr=3, so 0 beats 1
        set_data(0, 8'h5C); set_data(1, 8'hC5); set_data(2, 8'h7E);
        push_exp(2, 8'h7E);
        bus.Req = 4'b0100;
        drain("wrap_a");
        push_exp(0, 8'h5C); push_exp(1, 8'hC5);
        bus.Req = 4'b0011;
        drain("wrap_b");

        // Abort: ptr=1, requester 1 withdraws during GRANT
        set_data(0, 8'h3C); set_data(1, 8'hE1);
        push_exp(0, 8'h3C);
        bus.Req = 4'b0001;
        drain("abort_pre");
        bus.Req = 4'b0010;
        tick();
        chk("abort_grant", {28'b0, bus.Grant}, 32'h2);
        bus.Req = 4'b0000;
        tick();
        chk("abort_no_grant", {28'b0, bus.Grant}, 32'h0);
        chk("abort_no_ack", {28'b0, bus.Ack}, 32'h0);
        chk("abort_q", {24'b0, bus.Q}, 32'h3C);
        chk("abort_busy", {31'b0, bus.Busy}, 32'h0);
        push_exp(1, 8'hE1); push_exp(0, 8'h3C);
        bus.Req = 4'b0011;
        drain("abort_post");

        // Reset during GRANT (ptr=1 beforehand)
        set_data(2, 8'h99);
        bus.Req = 4'b0100;
        tick();
        chk("rmw_grant", {28'b0, bus.Grant}, 32'h4);
        Clear = 1'b0;
        tick();
        chk("rmw_ack", {28'b0, bus.Ack}, 32'h0);
        chk("rmw_q", {24'b0, bus.Q}, 32'h00);
        chk("rmw_qbar", {24'b0, bus.Qbar}, 32'hFF);
        chk("rmw_grant0", {28'b0, bus.Grant}, 32'h0);
        chk("rmw_busy", {31'b0, bus.Busy}, 32'h0);
        Clear = 1'b1;
        bus.Req = '0;
        tick();
        set_data(0, 8'h0F); set_data(3, 8'hF0);
        push_exp(0, 8'h0F); push_exp(3, 8'hF0);
        bus.Req = 4'b1001;
        drain("rmw_ptr");

`ifdef DFF_ARB_LOCK_EN
        // Locked requester 1 writes every 2 cycles, then 2 wins once Lock drops
        set_data(1, 8'h6B); set_data(2, 8'hB6);
        for (int i = 0; i < 3; i++) push_exp(1, 8'h6B);
        auto_drop = 1'b0;
        c0 = cyc;
        begin
            int base, n;
            base = ack_cnt; n = 0;
            bus.Req = 4'b0010;
            bus.Lock = 4'b0010;
            while (ack_cnt < base + 3 && n < 30) begin
                tick();
                n++;
            end
            chk("lock_acks", ack_cnt - base, 3);
        end
        chk("lock_rate", last_ack_cyc - c0, 6);
        bus.Lock = '0;
        bus.Req = 4'b0110;
        auto_drop = 1'b1;
        push_exp(2, 8'hB6); push_exp(1, 8'h6B);
        drain("lock_release");
`endif

        tick();
        chk("final_idle", {31'b0, bus.Busy}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin write arbiter for a shared WIDTH-bit D flip-flop register bank (Q/Qbar pair per bit).
- Up to NREQ requesters compete for write access; one write is granted, performed and acknowledged at a time.
- Sits between requester logic and the shared register bank. It owns the bank's Q/Qbar state, so no requester drives the flops directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register bank width in bits.

Ports:
- Clock  input  1  rising-edge clock.
- Clear  input  1  synchronous active-low reset; sampled on the rising edge of Clock.
- Req  input  NREQ  per-requester write request, level; held until Ack or withdrawn.
- WrData  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- Grant  output  NREQ  one-hot registered grant.
- Ack  output  NREQ  one-hot, one-cycle write-complete pulse.
- Q  output  WIDTH  register bank contents.
- Qbar  output  WIDTH  bitwise complement of Q, always.
- Busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered. All logic is clocked on the rising edge of Clock; there are no asynchronous paths.
- Reset (Clear==0 at an edge), with priority over everything else:
  - state=IDLE, Q=0, Qbar=all ones, Grant=0, Ack=0, Busy=0, round-robin pointer ptr=0.
  - Reset mid-GRANT or mid-DONE aborts the write: no Ack, Q is cleared.
- States: IDLE, GRANT, DONE.
- IDLE:
  - If Req!=0, select the first i with Req[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - Next cycle: Grant=onehot(i), state=GRANT, Busy=1.
  - If Req==0, remain in IDLE.
- GRANT:
  - If Req[i] is still 1: at the edge, Q<=WrData[i], Qbar<=~WrData[i], Ack<=onehot(i), Grant<=0, ptr<=(i+1) mod NREQ, state=DONE.
  - If Req[i] has dropped: abort. Q is unchanged, no Ack, Grant<=0, ptr unchanged, state=IDLE.
- DONE:
  - Ack is high for exactly this cycle. Next edge: Ack<=0, state=IDLE.
  - The requester must drop Req in the cycle it sees Ack. A Req still high in IDLE afterwards is treated as a new request.
- Latency: Req first high in cycle N (IDLE) -> Grant in cycle N+1 -> Q updated and Ack in cycle N+2.
- Throughput: one write per 3 cycles when requests are continuous.
- Invariants: Grant and Ack are never both nonzero. At most one bit of each is set. Q changes only on a completed write or on reset.
- Requests arriving while Busy are held off and considered in the next IDLE cycle.
- The WrData of non-granted requesters is ignored.
- Wrap-around: after granting NREQ-1, ptr=0.

Optional Feature:
- Macro: DFF_ARB_LOCK_EN.
- When defined:
  - Adds input port Lock (NREQ bits).
  - In DONE, if Req[i]&Lock[i] for the just-acknowledged i, go directly to GRANT with Grant=onehot(i). This skips IDLE, giving 2 cycles per write.
  - ptr is still updated to (i+1) mod NREQ, so arbitration resumes fairly once Lock drops.
  - Ack still pulses once per write.
- When undefined: no Lock port; DONE always returns to IDLE.

Test Plan:
- Reset: Clear=0 for 2 edges with random Req/WrData -> Q=8'h00, Qbar=8'hFF, Grant=0, Ack=0, Busy=0; release Clear with Req=0 -> all outputs unchanged.
- Single write: Req=4'b0100, WrData[2]=8'hA5 at cycle N -> Grant=4'b0100 at N+1; at N+2 Q=8'hA5, Qbar=8'h5A, Ack=4'b0100 for one cycle; Busy=0 at N+3.
- Round-robin: Req=4'b1111 held, each requester dropping Req on its Ack -> grant order 0,1,2,3; restart with Req=4'b1001 -> 0 then 3; then Req=4'b0001 again -> 0.
- Wrap: ptr=3 after granting 2, Req=4'b0011 -> requester 0 granted before 1.
- Abort: Req[1] granted, Req[1] dropped during GRANT -> no Ack, Q unchanged, next request from requester 1 is still favoured (ptr unchanged).
- Reset mid-write: Clear=0 in GRANT cycle -> no Ack, Q=0, state IDLE, ptr=0. With DFF_ARB_LOCK_EN: Req=Lock=4'b0010 held -> Ack[1] every 2 cycles; drop Lock with Req=4'b0110 -> requester 2 granted next.
